// File: rtl/fpm_pkg.sv
// fpm_pkg: shared result classes and IEEE-754 single-precision constants for the multiplier result stage.
package fpm_pkg;
  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    ZERO     = 3'd1,
    QNAN     = 3'd2,
    INF      = 3'd3,
    OVF_INF  = 3'd4,
    UNF_ZERO = 3'd5
  } fp_class_e;
  localparam logic [30:0] FP_QNAN_MAG  = 31'h7FC00000;
  localparam logic [30:0] FP_INF_MAG   = 31'h7F800000;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
endpackage

// File: rtl/fpm_fifo.sv
// fpm_fifo: synchronous FIFO; head word holds its last popped value while empty.
module fpm_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty   = wr_ptr == rd_ptr;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fpm_result_stage.sv
// fpm_result_stage: canonicalises and classifies multiplier results into a FIFO.
// Statistics counters exist only when FPM_RESULT_STATS_EN is defined.
module fpm_result_stage
  import fpm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_sign,
  input  logic             in_nan,
  input  logic             in_inf,
  input  logic             in_of,
  input  logic             in_uf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_class,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_of,
  output logic [CNT_W-1:0] stat_uf,
  output logic [CNT_W-1:0] stat_nan
);
  fp_class_e   cls;
  logic [31:0] res;
  logic [34:0] rdata;
  logic        full, empty, push;
  // zero outranks nan/inf because the multiplier lets a zero operand dominate
  always_comb begin
    cls = NORMAL;
    res = in_result;
    if (in_of) begin
      cls = OVF_INF;
      res = {in_sign, FP_INF_MAG};
    end else if (in_uf) begin
      cls = UNF_ZERO;
      res = {in_sign, 31'h0};
    end else if (in_result[30:0] == 31'h0) begin
      cls = ZERO;
      res = {in_result[31], 31'h0};
    end else if (in_nan) begin
      cls = QNAN;
      res = {in_sign, FP_QNAN_MAG};
    end else if (in_inf) begin
      cls = INF;
      res = {in_sign, EXP_ALL_ONES, 23'h0};
    end
  end
  assign in_ready   = rst_n & ~full;
  assign push       = in_valid & in_ready;
  assign out_valid  = ~empty;
  assign out_result = rdata[31:0];
  assign out_class  = rdata[34:32];
  fpm_fifo #(.WIDTH(35), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (out_valid & out_ready),
    .wdata ({cls, res}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );
`ifdef FPM_RESULT_STATS_EN
  logic [CNT_W-1:0] stat_of_q, stat_uf_q, stat_nan_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_of_q  <= '0;
      stat_uf_q  <= '0;
      stat_nan_q <= '0;
    end else if (stat_clr) begin
      stat_of_q  <= '0;
      stat_uf_q  <= '0;
      stat_nan_q <= '0;
    end else if (push) begin
      if (cls == OVF_INF && stat_of_q != '1) stat_of_q <= stat_of_q + 1'b1;
      if (cls == UNF_ZERO && stat_uf_q != '1) stat_uf_q <= stat_uf_q + 1'b1;
      if (cls == QNAN && stat_nan_q != '1) stat_nan_q <= stat_nan_q + 1'b1;
    end
  end
  assign stat_of  = stat_of_q;
  assign stat_uf  = stat_uf_q;
  assign stat_nan = stat_nan_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_of  = '0;
  assign stat_uf  = '0;
  assign stat_nan = '0;
`endif
endmodule

// File: doc/fpm_result_stage.md
Name: fpm_result_stage

Overview:
- Downstream stage of the combinational IEEE-754 single-precision multiplier.
- Registers the product and its NAN/INF/OF/UF flags behind a valid/ready handshake and buffers them in a small FIFO.
- Canonicalises every special result into a defined 32-bit word: no x reaches the consumer. OF becomes signed INF, UF becomes signed zero, and any NaN becomes a quiet NaN.
- Emits a 3-bit class code per result and, optionally, keeps per-event statistics counters.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product word presented.
- in_ready  out  1  stage can accept; equals !full.
- in_result  in  32  raw multiplier result; may be x when in_of/in_uf is set.
- in_sign  in  1  sign of the product (a[31]^b[31]).
- in_nan, in_inf, in_of, in_uf  in  1 each  multiplier flags.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_result  out  32  canonical result.
- out_class  out  3  0 NORMAL, 1 ZERO, 2 QNAN, 3 INF, 4 OVF_INF, 5 UNF_ZERO.
- stat_clr  in  1  synchronous clear of counters.
- stat_of, stat_uf, stat_nan  out  CNT_W each  saturating event counts.

Behaviour:
- Reset: asynchronous on rst_n low. FIFO pointers and count go to 0. out_valid=0, in_ready=0 while rst_n low, then 1. out_result=0, out_class=0, all counters 0.
- Reset mid-operation discards all buffered entries. No partial outputs.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Latency: a word pushed in cycle N is visible on out_* in N+1 if the FIFO was empty. There is no combinational fall-through.
- in_ready = !full. When full, no push is accepted even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- Empty: out_valid=0, and out_result/out_class hold their last value.
- Pointers wrap modulo DEPTH.
- Classification is evaluated combinationally at push. The canonical word is stored, not the raw word. Priority, first match wins:
  1. in_of → {in_sign, 8'hFF, 23'h0}, OVF_INF.
  2. in_uf → {in_sign, 31'h0}, UNF_ZERO.
  3. in_result[30:0]==0 → {in_result[31], 31'h0}, ZERO. This holds even if in_nan/in_inf is set, because zero dominates in the multiplier.
  4. in_nan → {in_sign, 8'hFF, 1'b1, 22'h0}, QNAN.
  5. in_inf → {in_sign, 8'hFF, 23'h0}, INF.
  6. otherwise in_result unchanged, NORMAL.
- in_result bits are never consulted when in_of or in_uf is set.
- Counters:
  - Increment by 1 on push only, for class OVF_INF (stat_of), UNF_ZERO (stat_uf) and QNAN (stat_nan).
  - Saturate at 2^CNT_W-1.
  - stat_clr has priority over an increment in the same cycle.

Optional Feature:
- Macro FPM_RESULT_STATS_EN.
- Defined: counters exist as specified above.
- Undefined: no counter flops. stat_* are tied to 0 and stat_clr is ignored. FIFO and classification are unchanged.

Decomposition:
- Package fpm_pkg holds:
  - class enum (NORMAL..UNF_ZERO, 3 bits).
  - FP_QNAN_MAG = 31'h7FC00000.
  - FP_INF_MAG = 31'h7F800000.
  - EXP_ALL_ONES = 8'hFF.
- Sub-module fpm_fifo: generic synchronous FIFO with parameters WIDTH=35 and DEPTH, and ports push/pop/full/empty.
- The top level holds the classifier and counters.

Test Plan:
- Reset then in_valid=1 with in_result=32'h4B555554 and no flags → next cycle out_valid=1, out_result=32'h4B555554, out_class=0.
- in_of=1, in_sign=0, in_result=32'hx → out_result=32'h7F800000, class 4, stat_of=1. Repeat with in_uf=1, in_sign=1 → 32'h80000000, class 5, stat_uf=1.
- in_result=32'h00000000 with in_nan=1 → out_result=32'h00000000, class 1, stat_nan unchanged. Then in_result=32'h7FFFFFFF with in_nan=1, in_sign=1 → 32'hFFC00000, class 2.
- out_ready=0 with DEPTH+2 pushes attempted → in_ready drops after 4 accepted. Drain with out_ready=1 → 4 words appear in order and out_valid=0 afterwards.
- Continuous push and pop every cycle for 20 cycles → count stays constant and data order is preserved through pointer wrap.
- With FIFO holding 3 entries, assert rst_n=0 mid-cycle → out_valid=0 immediately and counters=0. After release, the first new push appears alone.
- With FPM_RESULT_STATS_EN, force stat_of to 2^16-1 and push an OF → value holds. stat_clr together with an OF push → stat_of=0.
